dmem_arbiter: RTL and testbench

Arbiter and sequencer for the OTTER data-memory port (Memory port 2 / IOBUS path). It shares that single port between two requesters:
- the pipeline MEM stage (requester P);
- a debug/DMA loader (requester D).

It issues at most one transaction per cycle and routes each synchronous read response back to the requester that issued it. It raises `stall_m` so the hazard unit can hold the pipeline while P is denied. P has priority, but a starvation counter bounds D's wait, and D may lock the port for bounded bursts.

---
 rtl/dmem_arbiter.sv | 150 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Purpose : shares the OTTER data-memory port 2 between the pipeline MEM stage (P) and a debug/DMA loader (D).
// Latency : grant/ready combinational from req; read data returns exactly 1 cycle after the grant cycle.
// Backpr. : P has priority and D is forced in after STARVE_MAX contended cycles; a locked D burst holds off P for up to BURST_MAX beats.
// Ports   : p_* / d_* requester channels (req, we, addr, wdata, size, sign -> ready, rvalid, rdata), d_lock burst lock,
//           mem_* drive to Memory port 2, mem_dout read data back, stall_m hold request to the hazard unit.
module dmem_arbiter #(
    parameter int STARVE_MAX = 8,
    parameter int BURST_MAX  = 16
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        p_req,
    input  logic        p_we,
    input  logic [31:0] p_addr,
    input  logic [31:0] p_wdata,
    input  logic [1:0]  p_size,
    input  logic        p_sign,
    output logic        p_ready,
    output logic        p_rvalid,
    output logic [31:0] p_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [1:0]  d_size,
    input  logic        d_sign,
    input  logic        d_lock,
    output logic        d_ready,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        mem_rden,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_din,
    output logic [1:0]  mem_size,
    output logic        mem_sign,
    input  logic [31:0] mem_dout,
    output logic        stall_m
);

    typedef enum logic {ARB, DBURST} state_t;

    localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);
    localparam logic [7:0] BURST_LIM  = 8'(BURST_MAX);
    localparam bit         BURST_EN   = (BURST_MAX > 1);

    state_t     state;
    logic [7:0] starve_cnt;
    logic [7:0] burst_cnt;
    logic       rsp_valid;
    logic       rsp_owner;   // 0 = P, 1 = D

    logic p_gnt;
    logic d_gnt;
    logic gnt_we;

    // Grant decision; everything is suppressed while RESET is high.
    always_comb begin
        p_gnt = 1'b0;
        d_gnt = 1'b0;
        if (!RESET) begin
            if (state == DBURST) begin
                d_gnt = d_req;
                p_gnt = p_req & ~d_req;
            end else if (p_req && d_req) begin
                d_gnt = (starve_cnt == STARVE_LIM);
                p_gnt = (starve_cnt != STARVE_LIM);
            end else begin
                p_gnt = p_req;
                d_gnt = d_req;
            end
        end
    end

    assign gnt_we = d_gnt ? d_we : p_we;

    // Memory drive: granted requester's fields, all zero when idle.
    always_comb begin
        mem_rden = 1'b0;
        mem_we   = 1'b0;
        mem_addr = 32'd0;
        mem_din  = 32'd0;
        mem_size = 2'd0;
        mem_sign = 1'b0;
        if (d_gnt) begin
            mem_rden = ~d_we;
            mem_we   = d_we;
            mem_addr = d_addr;
            mem_din  = d_wdata;
            mem_size = d_size;
            mem_sign = d_sign;
        end else if (p_gnt) begin
            mem_rden = ~p_we;
            mem_we   = p_we;
            mem_addr = p_addr;
            mem_din  = p_wdata;
            mem_size = p_size;
            mem_sign = p_sign;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state      <= ARB;
            starve_cnt <= 8'd0;
            burst_cnt  <= 8'd0;
            rsp_valid  <= 1'b0;
            rsp_owner  <= 1'b0;
        end else begin
            rsp_valid <= (p_gnt | d_gnt) & ~gnt_we;
            rsp_owner <= d_gnt;

            if (!d_req || d_gnt)
                starve_cnt <= 8'd0;
            else if (starve_cnt != STARVE_LIM)
                starve_cnt <= starve_cnt + 8'd1;

            case (state)
                ARB: begin
                    // The locking grant itself is the first beat of the burst.
                    if (d_gnt && d_lock && BURST_EN) begin
                        state     <= DBURST;
                        burst_cnt <= 8'd1;
                    end
                end
                DBURST: begin
                    // In DBURST d_req implies a D grant, so this beat is counted here.
                    if (!d_lock || !d_req || (burst_cnt + 8'd1 == BURST_LIM)) begin
                        state     <= ARB;
                        burst_cnt <= 8'd0;
                    end else begin
                        burst_cnt <= burst_cnt + 8'd1;
                    end
                end
                default: state <= ARB;
            endcase
        end
    end

    assign p_ready  = p_gnt;
    assign d_ready  = d_gnt;
    assign stall_m  = p_req & ~p_gnt;

    // A response registered just before a reset edge must not leak out while RESET is high.
    assign p_rvalid = rsp_valid & ~rsp_owner & ~RESET;
    assign d_rvalid = rsp_valid &  rsp_owner & ~RESET;
    assign p_rdata  = p_rvalid ? mem_dout : 32'd0;
    assign d_rdata  = d_rvalid ? mem_dout : 32'd0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Purpose : self-checking bench for dmem_arbiter: directed scenarios with literal expectations, then random traffic vs a behavioural model.
// Latency : model checks every output on every cycle at the falling edge.
// Backpr. : random requesters keep their fields stable until granted, occasionally abandoning a request.
module tb_dmem_arbiter;

    localparam int STARVE = 8;
    localparam int BURST  = 4;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        p_req, p_we, p_sign;
    logic [31:0] p_addr, p_wdata;
    logic [1:0]  p_size;
    logic        p_ready, p_rvalid;
    logic [31:0] p_rdata;
    logic        d_req, d_we, d_sign, d_lock;
    logic [31:0] d_addr, d_wdata;
    logic [1:0]  d_size;
    logic        d_ready, d_rvalid;
    logic [31:0] d_rdata;
    logic        mem_rden, mem_we, mem_sign;
    logic [31:0] mem_addr, mem_din, mem_dout;
    logic [1:0]  mem_size;
    logic        stall_m;

    int n_checks = 0;
    int n_fail   = 0;

    dmem_arbiter #(.STARVE_MAX(STARVE), .BURST_MAX(BURST)) dut (
        .CLK(CLK), .RESET(RESET),
        .p_req(p_req), .p_we(p_we), .p_addr(p_addr), .p_wdata(p_wdata), .p_size(p_size), .p_sign(p_sign),
        .p_ready(p_ready), .p_rvalid(p_rvalid), .p_rdata(p_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_size(d_size), .d_sign(d_sign),
        .d_lock(d_lock), .d_ready(d_ready), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_rden(mem_rden), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_size(mem_size), .mem_sign(mem_sign), .mem_dout(mem_dout), .stall_m(stall_m)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: who owns the port, how long D has waited, how many
    // beats the current lock has used, and which read is still in flight.
    // ------------------------------------------------------------------
    bit m_locked   = 0;
    int m_beats    = 0;
    int m_wait     = 0;
    bit m_pend     = 0;
    bit m_pend_d   = 0;

    always @(negedge CLK) begin
        bit          pg, dg, we, ev_p, ev_d;
        logic [31:0] ea, ed;
        logic [1:0]  es;
        logic        esg;
        pg = 0;
        dg = 0;
        if (!RESET) begin
            if (m_locked) begin
                dg = d_req;
                pg = p_req && !d_req;
            end else if (p_req && d_req) begin
                dg = (m_wait >= STARVE);
                pg = !dg;
            end else begin
                pg = p_req;
                dg = d_req;
            end
        end
        we  = dg ? d_we : (pg ? p_we : 1'b0);
        ea  = dg ? d_addr  : (pg ? p_addr  : 32'd0);
        ed  = dg ? d_wdata : (pg ? p_wdata : 32'd0);
        es  = dg ? d_size  : (pg ? p_size  : 2'd0);
        esg = dg ? d_sign  : (pg ? p_sign  : 1'b0);
        ev_p = !RESET && m_pend && !m_pend_d;
        ev_d = !RESET && m_pend && m_pend_d;

        chk("p_ready",  {31'd0, p_ready},  {31'd0, pg});
        chk("d_ready",  {31'd0, d_ready},  {31'd0, dg});
        chk("stall_m",  {31'd0, stall_m},  {31'd0, p_req && !pg});
        chk("mem_rden", {31'd0, mem_rden}, {31'd0, (pg || dg) && !we});
        chk("mem_we",   {31'd0, mem_we},   {31'd0, (pg || dg) && we});
        chk("mem_addr", mem_addr, ea);
        chk("mem_din",  mem_din,  ed);
        chk("mem_size_sign", {29'd0, mem_size, mem_sign}, {29'd0, es, esg});
        chk("p_rvalid", {31'd0, p_rvalid}, {31'd0, ev_p});
        chk("d_rvalid", {31'd0, d_rvalid}, {31'd0, ev_d});
        chk("p_rdata",  p_rdata, ev_p ? mem_dout : 32'd0);
        chk("d_rdata",  d_rdata, ev_d ? mem_dout : 32'd0);

        // Advance the model to the next edge.
        if (RESET) begin
            m_locked = 0; m_beats = 0; m_wait = 0; m_pend = 0; m_pend_d = 0;
        end else begin
            m_pend   = (pg || dg) && !we;
            m_pend_d = dg;
            if (!d_req || dg) m_wait = 0;
            else if (m_wait < STARVE) m_wait = m_wait + 1;
            if (!m_locked) begin
                if (dg && d_lock && BURST > 1) begin
                    m_locked = 1;
                    m_beats  = 1;
                end
            end else if (!d_lock || !d_req) begin
                m_locked = 0;
            end else begin
                m_beats = m_beats + 1;
                if (m_beats >= BURST) m_locked = 0;
            end
        end
    end

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        p_req = 0; d_req = 0; d_lock = 0; p_we = 0; d_we = 0;
    endtask

    bit p_gl, d_gl;

    initial begin
        RESET = 1; p_req = 1; d_req = 1; p_we = 0; d_we = 0; d_lock = 0;
        p_addr = 32'h10; d_addr = 32'h20; p_wdata = 0; d_wdata = 0;
        p_size = 2'd2; d_size = 2'd2; p_sign = 0; d_sign = 0; mem_dout = 0;

        // Reset held two cycles with both requesting.
        repeat (2) begin
            @(negedge CLK);
            chk("rst_p_ready", {31'd0, p_ready}, 32'd0);
            chk("rst_d_ready", {31'd0, d_ready}, 32'd0);
            chk("rst_mem_en", {30'd0, mem_rden, mem_we}, 32'd0);
            chk("rst_rvalid", {30'd0, p_rvalid, d_rvalid}, 32'd0);
            chk("rst_stall", {31'd0, stall_m}, 32'd1);
            next_cycle();
        end
        RESET = 0;

        // Continuous contention: D wins on the 9th contended cycle.
        for (int c = 1; c <= 10; c++) begin
            @(negedge CLK);
            chk("starve_p", {31'd0, p_ready}, {31'd0, c != 9});
            chk("starve_d", {31'd0, d_ready}, {31'd0, c == 9});
            chk("starve_stall", {31'd0, stall_m}, {31'd0, c == 9});
            next_cycle();
        end
        idle();
        next_cycle();

        // Uncontested P read.
        p_req = 1; p_we = 0; p_addr = 32'h100;
        @(negedge CLK);
        chk("unc_ready", {31'd0, p_ready}, 32'd1);
        chk("unc_rden", {31'd0, mem_rden}, 32'd1);
        chk("unc_addr", mem_addr, 32'h100);
        next_cycle();
        p_req = 0; mem_dout = 32'hCAFEF00D;
        @(negedge CLK);
        chk("unc_rvalid", {31'd0, p_rvalid}, 32'd1);
        chk("unc_rdata", p_rdata, 32'hCAFEF00D);
        chk("unc_d_rvalid", {31'd0, d_rvalid}, 32'd0);
        next_cycle();

        // Locked D burst reached through starvation, then P again.
        p_req = 1; d_req = 1; d_lock = 1; p_addr = 32'h40; d_addr = 32'h80;
        for (int c = 1; c <= 13; c++) begin
            @(negedge CLK);
            chk("burst_d", {31'd0, d_ready}, {31'd0, c >= 9 && c <= 12});
            chk("burst_p", {31'd0, p_ready}, {31'd0, !(c >= 9 && c <= 12)});
            chk("burst_stall", {31'd0, stall_m}, {31'd0, c >= 9 && c <= 12});
            next_cycle();
        end
        idle();
        next_cycle();

        // Interleaved reads from P then D, returned in order.
        p_req = 1; p_addr = 32'h200;
        @(negedge CLK);
        chk("il_p_ready", {31'd0, p_ready}, 32'd1);
        next_cycle();
        p_req = 0; d_req = 1; d_addr = 32'h300; mem_dout = 32'h11111111;
        @(negedge CLK);
        chk("il_p_rvalid", {31'd0, p_rvalid}, 32'd1);
        chk("il_p_rdata", p_rdata, 32'h11111111);
        chk("il_d_ready", {31'd0, d_ready}, 32'd1);
        chk("il_d_rvalid0", {31'd0, d_rvalid}, 32'd0);
        next_cycle();
        d_req = 0; mem_dout = 32'h22222222;
        @(negedge CLK);
        chk("il_d_rvalid", {31'd0, d_rvalid}, 32'd1);
        chk("il_d_rdata", d_rdata, 32'h22222222);
        chk("il_p_rvalid0", {31'd0, p_rvalid}, 32'd0);
        chk("il_p_rdata0", p_rdata, 32'd0);
        next_cycle();

        // Reset in the middle of a locked D read burst.
        d_req = 1; d_lock = 1; d_we = 0; d_addr = 32'h400;
        repeat (2) begin
            @(negedge CLK);
            chk("rb_d_ready", {31'd0, d_ready}, 32'd1);
            next_cycle();
        end
        RESET = 1;
        @(negedge CLK);
        chk("rb_rst_d_rvalid", {31'd0, d_rvalid}, 32'd0);
        chk("rb_rst_d_ready", {31'd0, d_ready}, 32'd0);
        next_cycle();
        RESET = 0; p_req = 1; p_addr = 32'h500;
        @(negedge CLK);
        chk("rb_post_d_rvalid", {31'd0, d_rvalid}, 32'd0);
        chk("rb_post_p_ready", {31'd0, p_ready}, 32'd1);
        chk("rb_post_d_ready", {31'd0, d_ready}, 32'd0);
        next_cycle();
        idle();
        next_cycle();

        // Random traffic; a pending request keeps its fields until granted.
        p_gl = 0; d_gl = 0;
        for (int i = 0; i < 4000; i++) begin
            if (!(p_req && !p_gl && $urandom_range(9) != 0)) begin
                p_req   = ($urandom_range(2) != 0);
                p_we    = $urandom_range(1) == 1;
                p_addr  = $urandom;
                p_wdata = $urandom;
                p_size  = 2'($urandom_range(2));
                p_sign  = $urandom_range(1) == 1;
            end
            if (!(d_req && !d_gl && $urandom_range(9) != 0)) begin
                d_req   = ($urandom_range(2) != 0);
                d_we    = $urandom_range(1) == 1;
                d_addr  = $urandom;
                d_wdata = $urandom;
                d_size  = 2'($urandom_range(2));
                d_sign  = $urandom_range(1) == 1;
            end
            if ($urandom_range(7) == 0) d_lock = ~d_lock;
            mem_dout = $urandom;
            RESET    = ($urandom_range(299) == 0);
            @(negedge CLK);
            p_gl = p_ready;
            d_gl = d_ready;
            next_cycle();
        end

        idle();
        RESET = 0;
        next_cycle();
        @(negedge CLK);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
